div_seq_ctrl: RTL

DIV_SEQ_CTRL -- requirements
Module: div_seq_ctrl

---
 rtl/div_seq_ctrl_pkg.sv | 14 +
 rtl/div_seq_ctrl_if.sv | 24 ++
 rtl/div_seq_ctrl_stage.sv | 23 ++
 rtl/div_seq_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_seq_ctrl_pkg;

    localparam int DIV_W = 8;
    localparam int REM_W = 9;
    localparam logic [2:0] ITER_LAST = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Handshake and operand/result bus between a requester and the divider.
interface div_seq_ctrl_if;
    import div_seq_ctrl_pkg::*;

    logic             start;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_zero, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_zero, quotient, remainder
    );

endinterface

// File: rtl/div_seq_ctrl_stage.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_seq_ctrl_stage
    import div_seq_ctrl_pkg::*;
(
    input  logic [REM_W-1:0] rem_in,
    input  logic             top_bit,
    input  logic [DIV_W-1:0] b,
    output logic [REM_W-1:0] rem_out,
    output logic             q_bit
);

    logic [REM_W:0] shifted;
    logic [REM_W:0] b_ext;

    // Shift the partial remainder left and keep the difference only when it does not go negative.
    always_comb begin
        shifted = {rem_in, top_bit};
        b_ext   = {2'b00, b};
        q_bit   = (shifted >= b_ext);
        rem_out = q_bit ? REM_W'(shifted - b_ext) : shifted[REM_W-1:0];
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequential 8-bit unsigned divider: one shared restoring stage reused over 8 RUN cycles.
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    div_seq_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] a_sh_q, a_sh_d;
    logic [DIV_W-1:0] b_q, b_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic [2:0]       cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;
    logic [DIV_W-1:0] quotient_q, quotient_d;
    logic [DIV_W-1:0] remainder_q, remainder_d;

    logic [REM_W-1:0] stage_rem;
    logic             stage_q_bit;

    div_seq_ctrl_stage u_div_stage (
        .rem_in  (rem_q),
        .top_bit (a_sh_q[DIV_W-1]),
        .b       (b_q),
        .rem_out (stage_rem),
        .q_bit   (stage_q_bit)
    );

    // Next-state and registered-output decode; results load on the edge that enters DONE.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_d         = b_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        div_zero_d  = div_zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (bus.divisor != '0) begin
                        a_sh_d     = bus.dividend;
                        b_d        = bus.divisor;
                        rem_d      = '0;
                        cnt_d      = '0;
                        div_zero_d = 1'b0;
                        state_d    = RUN;
                    end else begin
                        done_d      = 1'b1;
                        div_zero_d  = 1'b1;
                        quotient_d  = '1;
                        remainder_d = bus.dividend;
                        state_d     = DONE;
                    end
                end
            end
            RUN: begin
                rem_d  = stage_rem;
                a_sh_d = {a_sh_q[DIV_W-2:0], stage_q_bit};
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == ITER_LAST) begin
                    done_d      = 1'b1;
                    quotient_d  = {a_sh_q[DIV_W-2:0], stage_q_bit};
                    remainder_d = stage_rem[DIV_W-1:0];
                    state_d     = DONE;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_q         <= b_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule
